rspfifo_rd_ctrl: RTL and testbench

Read-side controller for the 560-bit dual-clock response FIFO, running entirely in the FIFO read-clock domain. It gates upstream request issue with a credit counter, so outstanding responses never exceed FIFO capacity. It drains the FIFO (normal mode, q valid one cycle after rdreq) into a small output buffer that presents a valid/ready response stream. It also supports a flush sequence that discards all outstanding responses.

---
 rtl/rspfifo_rd_ctrl_if.sv | 27 ++
 rtl/rspfifo_rd_ctrl.sv | 124 ++++++++++++
 tb/tb_rspfifo_rd_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rspfifo_rd_ctrl_if.sv
// rspfifo_rd_ctrl_if: request, FIFO read-port and response-stream signals of the read controller
interface rspfifo_rd_ctrl_if #(
    parameter int DATA_W  = 560,
    parameter int USEDW_W = 6
);
    logic               req_valid_in;
    logic               req_ready_in;
    logic               req_valid_out;
    logic               req_ready_out;
    logic [DATA_W-1:0]  fifo_q;
    logic               fifo_rdempty;
    logic [USEDW_W-1:0] fifo_rdusedw;
    logic               fifo_rdreq;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [DATA_W-1:0]  rsp_data;

    modport master (
        input  req_valid_in, req_ready_in, fifo_q, fifo_rdempty, fifo_rdusedw, rsp_ready,
        output req_valid_out, req_ready_out, fifo_rdreq, rsp_valid, rsp_data
    );

    modport slave (
        output req_valid_in, req_ready_in, fifo_q, fifo_rdempty, fifo_rdusedw, rsp_ready,
        input  req_valid_out, req_ready_out, fifo_rdreq, rsp_valid, rsp_data
    );
endinterface

// File: rtl/rspfifo_rd_ctrl.sv
// rspfifo_rd_ctrl: credit-gated read controller draining the response FIFO into a small output buffer
// Optional statistics outputs (stat_rsp_cnt, stat_max_usedw) are built when RSPFIFO_RD_CTRL_STATS_EN is defined
module rspfifo_rd_ctrl #(
    parameter int DATA_W     = 560,
    parameter int USEDW_W    = 6,
    parameter int CREDITS    = 64,
    parameter int OBUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               aclr,
    rspfifo_rd_ctrl_if.master  bus,
    input  logic               flush,
    output logic               flush_done,
    output logic               busy,
    output logic [USEDW_W:0]   credit_cnt,
    output logic               err_underflow
`ifdef RSPFIFO_RD_CTRL_STATS_EN
    ,
    output logic [31:0]        stat_rsp_cnt,
    output logic [USEDW_W-1:0] stat_max_usedw
`endif
);
    localparam int PW = $clog2(OBUF_DEPTH);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t            state, state_nx;
    logic [2:0]        cnt;
    logic [2:0]        occ_after;
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic              inflight, grant, issue, pop, capture, drain_empty;
    logic [DATA_W-1:0] mem [OBUF_DEPTH];

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(OBUF_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign grant             = state == RUN && credit_cnt < (USEDW_W+1)'(CREDITS);
    assign issue             = bus.req_valid_in & bus.req_ready_in & grant;
    assign bus.req_valid_out = bus.req_valid_in & grant;
    assign bus.req_ready_out = bus.req_ready_in & grant;
    assign bus.rsp_valid     = state != DRAIN && cnt != 3'd0;
    assign pop               = bus.rsp_valid & bus.rsp_ready;
    // occupancy left once this cycle's handshake retires; a read is allowed while it stays below depth
    assign occ_after         = cnt + {2'b0, inflight} - {2'b0, pop};
    assign bus.fifo_rdreq    = !bus.fifo_rdempty && (state == DRAIN || occ_after < 3'(OBUF_DEPTH));
    // data returning during a drain is thrown away instead of being buffered
    assign capture           = inflight && state != DRAIN;
    assign bus.rsp_data      = bus.rsp_valid ? mem[rd_ptr] : '0;
    assign drain_empty       = credit_cnt == '0 && cnt == 3'd0 && !inflight;
    assign busy              = credit_cnt != '0 || cnt != 3'd0 || inflight;

    // state register
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) state <= RUN;
        else      state <= state_nx;
    end

    // next-state: flush starts a drain, drain ends once nothing is owed or held
    always_comb begin
        state_nx = state == RUN   ? (flush ? DRAIN : RUN) :
                   state == DRAIN ? (drain_empty ? DONE : DRAIN) : RUN;
    end

    // outputs decoded from state
    always_comb begin
        flush_done = state == DONE;
    end

    // outstanding-response credits with underflow guard
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            credit_cnt    <= '0;
            err_underflow <= 1'b0;
        end else if (bus.fifo_rdreq && credit_cnt == '0) begin
            credit_cnt    <= '0;
            err_underflow <= 1'b1;
        end else begin
            credit_cnt <= credit_cnt + (USEDW_W+1)'(issue) - (USEDW_W+1)'(bus.fifo_rdreq);
        end
    end

    // output buffer bookkeeping; a drain empties it every cycle
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            inflight <= 1'b0;
            cnt      <= 3'd0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= bus.fifo_rdreq;
            if (state == DRAIN) begin
                cnt    <= 3'd0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                cnt <= cnt + {2'b0, capture} - {2'b0, pop};
                if (capture) wr_ptr <= nxt(wr_ptr);
                if (pop) rd_ptr <= nxt(rd_ptr);
            end
        end
    end

    // buffer storage, written with FIFO data one cycle after the read
    always_ff @(posedge clk) begin
        if (capture) mem[wr_ptr] <= bus.fifo_q;
    end

`ifdef RSPFIFO_RD_CTRL_STATS_EN
    // response count and FIFO high-water mark, cleared when a flush completes
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            stat_rsp_cnt   <= '0;
            stat_max_usedw <= '0;
        end else if (state == DRAIN && state_nx == DONE) begin
            stat_rsp_cnt   <= '0;
            stat_max_usedw <= '0;
        end else begin
            if (pop) stat_rsp_cnt <= stat_rsp_cnt + 32'd1;
            if (bus.fifo_rdusedw > stat_max_usedw) stat_max_usedw <= bus.fifo_rdusedw;
        end
    end
`endif
endmodule

// File: tb/tb_rspfifo_rd_ctrl.sv
// tb_rspfifo_rd_ctrl: vectors, corner sequences and randomized traffic against a FIFO/credit reference model
module tb_rspfifo_rd_ctrl;
    localparam int DW = 560;
    localparam int UW = 6;
    localparam int CR = 4;
    localparam int OD = 2;

    logic          clk = 1'b0;
    logic          aclr = 1'b1;
    logic          flush = 1'b0;
    logic          flush_done, busy, err_underflow;
    logic [UW:0]   credit_cnt;
`ifdef RSPFIFO_RD_CTRL_STATS_EN
    logic [31:0]   stat_rsp_cnt;
    logic [UW-1:0] stat_max_usedw;
`endif

    rspfifo_rd_ctrl_if #(.DATA_W(DW), .USEDW_W(UW)) bus ();

    rspfifo_rd_ctrl #(.DATA_W(DW), .USEDW_W(UW), .CREDITS(CR), .OBUF_DEPTH(OD)) dut (
        .clk(clk),
        .aclr(aclr),
        .bus(bus),
        .flush(flush),
        .flush_done(flush_done),
        .busy(busy),
        .credit_cnt(credit_cnt),
        .err_underflow(err_underflow)
`ifdef RSPFIFO_RD_CTRL_STATS_EN
        ,
        .stat_rsp_cnt(stat_rsp_cnt),
        .stat_max_usedw(stat_max_usedw)
`endif
    );

    always #5 clk = ~clk;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];
    logic          force_ne = 1'b0;

    // FIFO read port: q one cycle after rdreq, registered empty flag
    always @(posedge clk or posedge aclr) begin
        if (aclr) begin
            bus.fifo_rdempty <= 1'b1;
            bus.fifo_q       <= '0;
            bus.fifo_rdusedw <= '0;
        end else begin
            if (bus.fifo_rdreq && fq.size() > 0) bus.fifo_q <= fq.pop_front();
            bus.fifo_rdempty <= !force_ne && fq.size() == 0;
            bus.fifo_rdusedw <= UW'(fq.size());
        end
    end

    int total = 0, bad = 0, cyc = 0, iss = 0, pops = 0, delivered = 0, ntag = 0;
    bit mon_en = 1'b1, chk_grant = 1'b0;
    logic s_rdreq, s_valid, s_issue, s_done;
    logic prev_hold = 1'b0;
    logic [DW-1:0] prev_data;

    typedef struct {
        logic vin;
        logic rin;
        logic evo;
        logic ero;
        int   ecr;
    } vec_t;

    function automatic logic [DW-1:0] mk(input int tag);
        logic [15:0] t;
        t = 16'(tag);
        return {35{t}};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (low 64 bits)", name, act[63:0], exp[63:0]);
        end
    endtask

    task automatic push(input bit keep);
        fq.push_back(mk(ntag));
        if (keep) exp_q.push_back(mk(ntag));
        ntag++;
    endtask

    // one cycle: sample 1ns after the driving edge, score it, then advance to the next negedge
    task automatic tick();
        logic g;
        #1;
        s_rdreq = bus.fifo_rdreq;
        s_valid = bus.rsp_valid;
        s_issue = bus.req_valid_in & bus.req_ready_out;
        s_done  = flush_done;
        if (mon_en) begin
            if (s_rdreq && !force_ne) check("pop_nonempty", fq.size() != 0, 1);
            check("credit", credit_cnt, 64'(iss - pops));
            check("obuf_bound", (pops - delivered) <= OD + 1, 1);
            if (chk_grant) begin
                g = (iss - pops) < CR;
                check("req_ready_out", bus.req_ready_out, bus.req_ready_in & g);
                check("req_valid_out", bus.req_valid_out, bus.req_valid_in & g);
            end
            if (prev_hold) begin
                check("hold_valid", bus.rsp_valid, 1);
                check_data("hold_data", bus.rsp_data, prev_data);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                check("rsp_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check_data("rsp_data", bus.rsp_data, exp_q[0]);
                    void'(exp_q.pop_front());
                end
                delivered++;
            end
        end
        prev_hold = bus.rsp_valid && !bus.rsp_ready;
        prev_data = bus.rsp_data;
        if (s_rdreq) pops++;
        if (s_issue) iss++;
        cyc++;
        @(negedge clk);
    endtask

    task automatic issue_n(input int n);
        repeat (n) begin
            bus.req_valid_in = 1'b1;
            bus.req_ready_in = 1'b1;
            tick();
        end
        bus.req_valid_in = 1'b0;
        bus.req_ready_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tv[9];
        logic rq[12], vl[12];
        int f, d0, np, last_pop, done_at, ndone, last_due;
        int due[$];
        tv[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 0};
        tv[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 0};
        tv[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1};
        tv[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 2};
        tv[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 3};
        tv[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 4};
        tv[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 4};
        tv[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 4};
        tv[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 4};
        bus.req_valid_in = 1'b0;
        bus.req_ready_in = 1'b0;
        bus.rsp_ready    = 1'b0;
        repeat (3) @(negedge clk);
        aclr = 1'b0;
        #1;
        check("rst_req_valid_out", bus.req_valid_out, 0);
        check("rst_req_ready_out", bus.req_ready_out, 0);
        check("rst_rdreq", bus.fifo_rdreq, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data_zero", bus.rsp_data == '0, 1);
        check("rst_flush_done", flush_done, 0);
        check("rst_busy", busy, 0);
        check("rst_credit", credit_cnt, 0);
        check("rst_err", err_underflow, 0);
        @(negedge clk);

        // credit limit table
        for (int i = 0; i < 9; i++) begin
            bus.req_valid_in = tv[i].vin;
            bus.req_ready_in = tv[i].rin;
            #1;
            check("tab_valid_out", bus.req_valid_out, tv[i].evo);
            check("tab_ready_out", bus.req_ready_out, tv[i].ero);
            tick();
            check("tab_credit", credit_cnt, 64'(tv[i].ecr));
        end
        bus.req_valid_in = 1'b0;
        bus.req_ready_in = 1'b0;

        // four queued responses drain back to back
        bus.rsp_ready = 1'b1;
        repeat (4) push(1'b1);
        for (int i = 0; i < 12; i++) begin
            tick();
            rq[i] = s_rdreq;
            vl[i] = s_valid;
        end
        f = -1;
        for (int i = 0; i < 12; i++) if (f < 0 && rq[i]) f = i;
        check("first_pop", 64'(f), 1);
        for (int i = 0; i < 12; i++) begin
            check("pop_seq", rq[i], i >= f && i < f + 4);
            check("rsp_seq", vl[i], i >= f + 2 && i < f + 6);
        end
        check("burst_credit", credit_cnt, 0);
        check("burst_delivered", 64'(delivered), 4);

        // back-pressure: buffer stops at its depth, five responses arrive intact
        bus.rsp_ready = 1'b0;
        d0 = delivered;
        issue_n(4);
        repeat (4) push(1'b1);
        np = 0;
        repeat (10) begin
            tick();
            np += int'(s_rdreq);
        end
        check("bp_pops", 64'(np), OD);
        check("bp_credit", credit_cnt, 2);
        check("bp_valid", bus.rsp_valid, 1);
        issue_n(1);
        push(1'b1);
        repeat (6) begin
            tick();
            np += int'(s_rdreq);
        end
        check("bp_pops_held", 64'(np), OD);
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 40 && delivered < d0 + 5; k++) tick();
        check("bp_delivered", 64'(delivered - d0), 5);
        repeat (3) tick();
        check("bp_credit_end", credit_cnt, 0);
        check("bp_busy_end", busy, 0);

        // issue and pop in the same cycle
        issue_n(3);
        push(1'b1);
        tick();
        bus.req_valid_in = 1'b1;
        bus.req_ready_in = 1'b1;
        tick();
        check("same_cycle_pop", s_rdreq, 1);
        check("same_cycle_issue", s_issue, 1);
        bus.req_valid_in = 1'b0;
        bus.req_ready_in = 1'b0;
        check("same_cycle_credit", credit_cnt, 3);
        repeat (5) tick();
        check("pre_flush_credit", credit_cnt, 3);

        // flush with two responses in the FIFO and one arriving late
        push(1'b0);
        push(1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.req_valid_in = 1'b1;
        bus.req_ready_in = 1'b1;
        last_pop = -1;
        done_at = -1;
        for (int k = 0; k < 60; k++) begin
            if (k == 10) push(1'b0);
            tick();
            check("flush_rsp_valid", s_valid, 0);
            check("flush_no_issue", s_issue, 0);
            if (s_rdreq) last_pop = k;
            if (s_done) begin
                done_at = k;
                break;
            end
        end
        bus.req_valid_in = 1'b0;
        bus.req_ready_in = 1'b0;
        ndone = 0;
        repeat (3) begin
            tick();
            ndone += int'(s_done);
        end
        check("flush_done_seen", done_at >= 0, 1);
        check("flush_late_pop", 64'(last_pop), 11);
        check("flush_done_lat", (done_at - last_pop) >= 2 && (done_at - last_pop) <= 3, 1);
        check("flush_done_single", 64'(ndone), 0);
        check("flush_credit", credit_cnt, 0);
        check("flush_busy", busy, 0);

        // underflow: forced non-empty with no credits
        mon_en = 1'b0;
        bus.rsp_ready = 1'b0;
        force_ne = 1'b1;
        tick();
        force_ne = 1'b0;
        repeat (4) tick();
        check("uf_err", err_underflow, 1);
        check("uf_credit", credit_cnt, 0);
        repeat (5) tick();
        check("uf_sticky", err_underflow, 1);
        aclr = 1'b1;
        #1;
        check("uf_clear_err", err_underflow, 0);
        check("uf_clear_valid", bus.rsp_valid, 0);
        check("uf_clear_busy", busy, 0);
        @(negedge clk);
        aclr = 1'b0;
        fq.delete();
        exp_q.delete();
        iss = 0;
        pops = 0;
        delivered = 0;
        prev_hold = 1'b0;
        mon_en = 1'b1;
        tick();

        // randomized traffic with responses returning after random delays
        chk_grant = 1'b1;
        last_due = 0;
        for (int c = 0; c < 600; c++) begin
            while (due.size() > 0 && due[0] <= cyc) begin
                void'(due.pop_front());
                push(1'b1);
            end
            bus.req_valid_in = 1'($urandom_range(0, 1));
            bus.req_ready_in = $urandom_range(0, 3) != 0;
            bus.rsp_ready    = $urandom_range(0, 3) != 0;
            tick();
            if (s_issue) begin
                last_due = (cyc + int'($urandom_range(1, 8)) > last_due) ? cyc + int'($urandom_range(1, 8)) : last_due;
                due.push_back(last_due);
            end
        end
        bus.req_valid_in = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 300 && (due.size() > 0 || exp_q.size() > 0 || busy); k++) begin
            while (due.size() > 0 && due[0] <= cyc) begin
                void'(due.pop_front());
                push(1'b1);
            end
            tick();
        end
        check("rand_all_delivered", 64'(exp_q.size()), 0);
        check("rand_count", 64'(delivered), 64'(iss));
        check("rand_credit", credit_cnt, 0);
        check("rand_busy", busy, 0);
        check("rand_err", err_underflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
